spi_controller: RTL and testbench
=================================

Name: spi_controller

Overview:
- SPI mode-0 write controller; the transmitting end of the team's 16-bit register-write SPI link.
- Accepts one register-write command per valid/ready handshake on the `clk` domain.
- Serialises each command as a single 16-bit frame on `cs_n`/`sclk`/`copi`, towards the on-chip SPI peripheral or an external peripheral in test fixtures.
- Generates `sclk` by dividing `clk`; no second clock domain inside the block.

Parameters:
- CLK_DIV, 4, `clk` cycles per `sclk` half-period (D). Legal range 4..255; the receiver's 2-FF `copi` synchroniser requires D ≥ 4.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- cmd_valid, input, 1, command request.
- cmd_ready, output, 1, controller can accept a command.
- cmd_write, input, 1, frame bit 15 (1 = write).
- cmd_addr, input, 7, register address (frame bits 14:8).
- cmd_data, input, 8, register data (frame bits 7:0).
- busy, output, 1, high from the accept cycle until `cmd_ready` returns.
- done, output, 1, one-cycle pulse when `cs_n` deasserts at end of frame.
- cmd_err, output, 1, one-cycle address-reject pulse (see Optional Feature).
- sclk, output, 1, SPI clock; idles low.
- cs_n, output, 1, chip select, active-low; idles high.
- copi, output, 1, serial data, MSB (bit 15) first.

Behaviour:
- Reset values (async on `rst_n` low): `cs_n`=1, `sclk`=0, `copi`=0, `cmd_ready`=1, `busy`=0, `done`=0, `cmd_err`=0. The state machine goes to IDLE and the bit counter and divider clear.
- Reset mid-frame aborts the frame immediately; no `done` pulse is produced.
- Accept: occurs on a cycle T where `cmd_valid` && `cmd_ready`.
  - The shift register latches {`cmd_write`, `cmd_addr`, `cmd_data`}. Inputs are don't-care after T.
  - `cmd_ready` goes 0 and `busy` goes 1 from T+1.
- States: IDLE → SETUP → SHIFT → GAP → IDLE (plus ERR with the optional feature).
- SETUP, cycles T+1..T+D:
  - `cs_n`=0, `sclk`=0.
  - `copi` = bit 15.
- SHIFT: for bit i = 0..15 (MSB first):
  - `sclk` is high for D cycles starting at T+1+D+2Di, then low for D cycles.
  - `copi` changes only on the cycle `sclk` falls, to the next bit. The value after the last fall is don't-care; drive 0.
  - Exactly 16 rising edges are produced.
  - The final low phase is the `cs_n` hold time.
- End of frame:
  - `cs_n` is low for exactly 33D cycles (T+1..T+33D).
  - At T+1+33D: `cs_n`=1, `done`=1 for one cycle, state → GAP.
- GAP: `cs_n` high for D cycles. `cmd_ready` returns to 1 at T+1+34D; `busy` falls the same cycle.
- Back-to-back: if `cmd_valid` is held, the next accept is at T+1+34D and the next `cs_n` fall is one cycle later.
- `cmd_valid` while `cmd_ready`=0 is ignored; there is no queueing.
- Divider: a counter 0..D-1 resets at each phase boundary; `sclk` is a registered output with no glitches.
- `sclk` and `cs_n` never change on the same cycle.

Optional Feature:
- Macro: SPI_CTRL_ADDR_CHECK_EN.
- Defined: at accept, if `cmd_addr` > 4, no frame is sent.
  - State → ERR for one cycle: `cmd_err`=1 at T+1, `cmd_ready`=0, `busy`=1, `cs_n` stays high.
  - `cmd_ready` returns at T+2.
- Undefined: `cmd_err` is tied 0; any address is transmitted unchanged.

Test Plan:
- Write addr 0x00, data 0xF0, D=4, accept at T: bits sampled on `sclk` rises = 1000_0000_1111_0000 (0x80F0); `cs_n` low 132 cycles; 16 rises; `done` at T+133; `cmd_ready` at T+137.
- `cmd_write`=0, addr 0x03, data 0xA5: sampled frame = 0x03A5; a peripheral model's registers are unchanged.
- Two commands with `cmd_valid` held (0x8155 then 0x82AA): second accept at T+137; `cs_n` falls at T+138; `cs_n` high ≥4 cycles between frames; both frames decoded correctly.
- `rst_n` pulsed after the 5th `sclk` rise: `cs_n`=1, `sclk`=0, `copi`=0 asynchronously; no `done`; next command (0x8412) sends a full 16-rise frame.
- SPI_CTRL_ADDR_CHECK_EN defined, addr 0x05: `cs_n` never falls; `cmd_err`=1 at T+1 only; `cmd_ready`=1 at T+2. Undefined: frame 0x85xx is transmitted and `cmd_err` stays 0.
- CLK_DIV=6, frame 0x8201: `cs_n` low 198 cycles; each `sclk` phase 6 cycles; `copi` stable ≥6 cycles around each rise.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: one 16-bit {write, addr[6:0], data[7:0]} frame per accepted command.
// Optional address rejection is enabled with `define SPI_CTRL_ADDR_CHECK_EN.
module spi_controller #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic       cmd_err,
   output logic       sclk,
   output logic       cs_n,
   output logic       copi
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, ERR} state_t;

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [4:0] HALF_LAST = 5'd31;

   state_t      state_r, state_s;
   logic [7:0]  div_r, div_s;
   logic [4:0]  half_r, half_s;
   logic [15:0] shreg_r, shreg_s;
   logic        cs_n_r, cs_n_s;
   logic        sclk_r, sclk_s;
   logic        ready_r, ready_s;
   logic        busy_r, busy_s;
   logic        done_r, done_s;
   logic        err_r, err_s;
   logic        div_end_s;
   logic        reject_s;

`ifdef SPI_CTRL_ADDR_CHECK_EN
   assign reject_s = (cmd_addr > 7'd4);
`else
   assign reject_s = 1'b0;
`endif

   assign div_end_s = (div_r == DIV_LAST);

   // Next-state, divider, shift and output-register logic
   always_comb begin
      state_s = state_r;
      div_s   = div_r + 8'd1;
      half_s  = half_r;
      shreg_s = shreg_r;
      cs_n_s  = cs_n_r;
      sclk_s  = sclk_r;
      ready_s = ready_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            div_s = 8'd0;
            if (cmd_valid && ready_r) begin
               ready_s = 1'b0;
               busy_s  = 1'b1;
               if (reject_s) begin
                  state_s = ERR;
                  err_s   = 1'b1;
               end else begin
                  state_s = SETUP;
                  shreg_s = {cmd_write, cmd_addr, cmd_data};
                  cs_n_s  = 1'b0;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            if (div_end_s) begin
               state_s = SHIFT;
               div_s   = 8'd0;
               half_s  = 5'd0;
               sclk_s  = 1'b1;
            end else begin
               state_s = SETUP;
            end
         end
         SHIFT: begin
            // Even half-phases are sclk high; leaving one is a falling edge, so copi advances
            if (div_end_s) begin
               div_s = 8'd0;
               if (half_r == HALF_LAST) begin
                  state_s = GAP;
                  cs_n_s  = 1'b1;
                  done_s  = 1'b1;
               end else begin
                  half_s = half_r + 5'd1;
                  sclk_s = half_r[0];
                  if (!half_r[0]) begin
                     shreg_s = {shreg_r[14:0], 1'b0};
                  end else begin
                     shreg_s = shreg_r;
                  end
               end
            end else begin
               state_s = SHIFT;
            end
         end
         GAP: begin
            if (div_end_s) begin
               state_s = IDLE;
               div_s   = 8'd0;
               ready_s = 1'b1;
               busy_s  = 1'b0;
            end else begin
               state_s = GAP;
            end
         end
         ERR: begin
            state_s = IDLE;
            div_s   = 8'd0;
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = IDLE;
            div_s   = 8'd0;
            half_s  = 5'd0;
            shreg_s = 16'd0;
            cs_n_s  = 1'b1;
            sclk_s  = 1'b0;
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         div_r   <= 8'd0;
         half_r  <= 5'd0;
         shreg_r <= 16'd0;
         cs_n_r  <= 1'b1;
         sclk_r  <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         div_r   <= div_s;
         half_r  <= half_s;
         shreg_r <= shreg_s;
         cs_n_r  <= cs_n_s;
         sclk_r  <= sclk_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         err_r   <= err_s;
      end
   end

   // copi is the shift-register MSB; zeros shifted in make the post-frame value 0
   assign copi      = shreg_r[15];
   assign cs_n      = cs_n_r;
   assign sclk      = sclk_r;
   assign cmd_ready = ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign cmd_err   = err_r;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV 4 and 6), a cycle-offset reference model
// compared every cycle, directed literal checks and randomized traffic.
module tb_spi_controller;

   localparam int DA = 4;
   localparam int DB = 6;

   logic            clk;
   logic            rst_n;
   logic [1:0]      cmd_valid, cmd_write, cmd_ready, busy, done, cmd_err, sclk, cs_n, copi;
   logic [1:0][6:0] cmd_addr;
   logic [1:0][7:0] cmd_data;

   int vectors;
   int miscompares;
   int cyc;

   spi_controller #(.CLK_DIV(DA)) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
      .busy(busy[0]), .done(done[0]), .cmd_err(cmd_err[0]),
      .sclk(sclk[0]), .cs_n(cs_n[0]), .copi(copi[0])
   );

   spi_controller #(.CLK_DIV(DB)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
      .busy(busy[1]), .done(done[1]), .cmd_err(cmd_err[1]),
      .sclk(sclk[1]), .cs_n(cs_n[1]), .copi(copi[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dv(input int u);
      return (u == 0) ? DA : DB;
   endfunction

   function automatic logic rejects(input logic [6:0] a);
`ifdef SPI_CTRL_ADDR_CHECK_EN
      return (a > 7'd4);
`else
      return 1'b0;
`endif
   endfunction

   // Expected {cs_n, sclk, copi, ready, busy, done, err} k cycles after an accept (k=0: idle)
   function automatic logic [6:0] model_out(input int k, input logic [15:0] f, input logic e, input int d);
      logic cs, sc, co, rd, bz, dn, er;
      int falls;
      cs = 1'b1; sc = 1'b0; co = 1'b0; rd = 1'b0; bz = 1'b1; dn = 1'b0; er = 1'b0;
      if (k == 0) begin
         rd = 1'b1;
         bz = 1'b0;
      end else if (e) begin
         er = 1'b1;
      end else if (k <= 33 * d) begin
         cs = 1'b0;
         sc = (k > d) && ((((k - 1 - d) / d) % 2) == 0);
         falls = (k >= 1 + 2 * d) ? ((k - 1 - 2 * d) / (2 * d) + 1) : 0;
         co = (falls < 16) ? f[15 - falls] : 1'b0;
      end else begin
         dn = (k == 33 * d + 1);
      end
      return {cs, sc, co, rd, bz, dn, er};
   endfunction

   int          m_k[2];
   logic [15:0] m_f[2];
   logic        m_e[2];
   int          m_t[2];

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: cycles elapsed since the last accepted command, per instance
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int u = 0; u < 2; u++) m_k[u] <= 0;
      end else begin
         for (int u = 0; u < 2; u++) begin
            if (m_k[u] == 0) begin
               if (cmd_valid[u]) begin
                  m_k[u] <= 1;
                  m_f[u] <= {cmd_write[u], cmd_addr[u], cmd_data[u]};
                  m_e[u] <= rejects(cmd_addr[u]);
                  m_t[u] <= cyc;
               end
            end else if (m_k[u] >= (m_e[u] ? 1 : 34 * dv(u))) begin
               m_k[u] <= 0;
            end else begin
               m_k[u] <= m_k[u] + 1;
            end
         end
      end
   end

   int          rises[2], cs_run[2], last_rises[2], last_cs_low[2], done_cyc[2], fall_cyc[2];
   logic [15:0] rx_sh[2], last_rx[2];
   logic        prev_cs[2], prev_sclk[2];

   // Per-cycle comparison against the model, plus a peripheral-side frame decoder
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         logic [6:0] exp_v, act_v;
         exp_v = model_out(m_k[u], m_f[u], m_e[u], dv(u));
         act_v = {cs_n[u], sclk[u], copi[u], cmd_ready[u], busy[u], done[u], cmd_err[u]};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle u%0d cyc %0d: {cs_n,sclk,copi,ready,busy,done,err} got %b expected %b",
                     u, cyc, act_v, exp_v);
         end
         if (!cs_n[u] && prev_cs[u]) begin
            rises[u] = 0; cs_run[u] = 0; rx_sh[u] = 16'd0; fall_cyc[u] = cyc;
         end
         if (!cs_n[u]) cs_run[u]++;
         if (!cs_n[u] && sclk[u] && !prev_sclk[u]) begin
            rx_sh[u] = {rx_sh[u][14:0], copi[u]};
            rises[u]++;
         end
         if (cs_n[u] && !prev_cs[u]) begin
            last_rx[u] = rx_sh[u]; last_rises[u] = rises[u]; last_cs_low[u] = cs_run[u];
         end
         if (done[u]) done_cyc[u] = cyc;
         prev_cs[u]   = cs_n[u];
         prev_sclk[u] = sclk[u];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input int u, input logic [15:0] f, input bit hold);
      bit r;
      int n;
      cmd_write[u] = f[15];
      cmd_addr[u]  = f[14:8];
      cmd_data[u]  = f[7:0];
      cmd_valid[u] = 1'b1;
      r = 1'b0;
      n = 0;
      while (!r && n < 600) begin
         @(negedge clk);
         r = cmd_ready[u];
         @(posedge clk);
         n++;
      end
      if (!r) begin
         vectors++;
         miscompares++;
         $display("FAIL send u%0d: command 0x%0h not accepted within 600 cycles", u, f);
      end
      #1;
      if (!hold) begin
         cmd_valid[u] = 1'b0;
         cmd_write[u] = 1'($urandom);
         cmd_addr[u]  = 7'($urandom);
         cmd_data[u]  = 8'($urandom);
      end
   endtask

   task automatic wait_done(input int u);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[u] && n < 1000);
      #1;
      if (!done[u]) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_done u%0d: done not seen within 1000 cycles", u);
      end
   endtask

   task automatic wait_ready(input int u, output int at);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!cmd_ready[u] && n < 1000);
      at = cyc;
      if (!cmd_ready[u]) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_ready u%0d: cmd_ready not seen within 1000 cycles", u);
      end
   endtask

   initial begin
      int t1, t2, rc, n;
      vectors = 0; miscompares = 0; cyc = 0;
      for (int u = 0; u < 2; u++) begin
         prev_cs[u] = 1'b1; prev_sclk[u] = 1'b0; rx_sh[u] = 16'd0; last_rx[u] = 16'd0;
         rises[u] = 0; cs_run[u] = 0; m_k[u] = 0; m_e[u] = 1'b0; m_f[u] = 16'd0; m_t[u] = 0;
      end
      cmd_valid = 2'b00; cmd_write = 2'b00; cmd_addr = '0; cmd_data = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {25'd0, cs_n[0], sclk[0], copi[0], cmd_ready[0], busy[0], done[0], cmd_err[0]},
            32'b1001000);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write addr 0x00 data 0xF0, D=4
      send(0, 16'h80F0, 1'b0);
      t1 = m_t[0];
      wait_ready(0, rc);
      check("f80F0_rx", 32'(last_rx[0]), 32'h80F0);
      check("f80F0_rises", 32'(last_rises[0]), 32'd16);
      check("f80F0_cs_low", 32'(last_cs_low[0]), 32'd132);
      check("f80F0_done_at", 32'(done_cyc[0] - t1), 32'd133);
      check("f80F0_ready_at", 32'(rc - t1), 32'd137);

      // Read-flagged frame is transmitted with bit 15 clear
      send(0, 16'h03A5, 1'b0);
      wait_done(0);
      check("f03A5_rx", 32'(last_rx[0]), 32'h03A5);

      // Back-to-back with cmd_valid held
      wait_ready(0, rc);
      send(0, 16'h8155, 1'b1);
      t1 = m_t[0];
      cmd_write[0] = 1'b1; cmd_addr[0] = 7'h02; cmd_data[0] = 8'hAA;
      send(0, 16'h82AA, 1'b0);
      t2 = m_t[0];
      check("b2b_accept_gap", 32'(t2 - t1), 32'd137);
      check("b2b_first_rx", 32'(last_rx[0]), 32'h8155);
      @(negedge clk);
      #1;
      check("b2b_cs_fall_at", 32'(fall_cyc[0] - t2), 32'd1);
      wait_done(0);
      check("b2b_second_rx", 32'(last_rx[0]), 32'h82AA);

      // Reset after the 5th sclk rise aborts the frame
      wait_ready(0, rc);
      send(0, 16'h8C33, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (rises[0] < 5 && n < 300);
      check("rst_reached_rise5", 32'(rises[0]), 32'd5);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_pins", {29'd0, cs_n[0], sclk[0], copi[0]}, 32'b100);
      @(negedge clk);
      #2 rst_n = 1'b1;
      send(0, 16'h8412, 1'b0);
      wait_done(0);
      check("after_rst_rx", 32'(last_rx[0]), 32'h8412);
      check("after_rst_rises", 32'(last_rises[0]), 32'd16);

      // Address 0x05: rejected with the check enabled, sent otherwise
      wait_ready(0, rc);
      send(0, 16'h8577, 1'b0);
`ifdef SPI_CTRL_ADDR_CHECK_EN
      @(negedge clk);
      #1;
      check("a05_err_t1", {30'd0, cmd_err[0], cmd_ready[0]}, 32'b10);
      @(negedge clk);
      #1;
      check("a05_ready_t2", {30'd0, cmd_err[0], cmd_ready[0]}, 32'b01);
`else
      wait_done(0);
      check("a05_rx", 32'(last_rx[0]), 32'h8577);
`endif

      // CLK_DIV=6 instance
      send(1, 16'h8201, 1'b0);
      t1 = m_t[1];
      wait_done(1);
      check("d6_rx", 32'(last_rx[1]), 32'h8201);
      check("d6_cs_low", 32'(last_cs_low[1]), 32'd198);
      check("d6_rises", 32'(last_rises[1]), 32'd16);
      check("d6_done_at", 32'(done_cyc[1] - t1), 32'd199);

      // Randomized traffic on both instances, checked every cycle by the model
      repeat (4000) begin
         @(posedge clk);
         #1;
         for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = ($urandom_range(0, 2) == 0);
            cmd_write[u] = 1'($urandom);
            cmd_addr[u]  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7)) : 7'($urandom);
            cmd_data[u]  = 8'($urandom);
         end
      end
      cmd_valid = 2'b00;
      repeat (10) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
